// File: rtl/timer_alarm_if.sv
// -----------------------------------------------------------------------------
// timer_alarm_if
//
// This interface carries the CPU-side I/O bus of timer_alarm.
//
// Signals:
//   cs    chip select
//   rd    read strobe (one cycle, qualified by cs)
//   wr    write strobe (one cycle, qualified by cs)
//   addr  register index (0..7)
//   din   write data
//   dout  registered read data (driven by the slave)
//   irq   level interrupt request (driven by the slave)
//
// Modports:
//   master  the CPU / address decode side
//   slave   the timer_alarm side
// -----------------------------------------------------------------------------
interface timer_alarm_if;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    modport master (
        output cs, rd, wr, addr, din,
        input  dout, irq
    );

    modport slave (
        input  cs, rd, wr, addr, din,
        output dout, irq
    );
endinterface : timer_alarm_if

// File: rtl/timer_alarm.sv
// -----------------------------------------------------------------------------
// timer_alarm
//
// This block connects the free-running system tick counter to an 8-bit CPU
// bus. It provides the following:
//   - tear-free 16-bit counter reads: reading CNT_LO also snapshots the high
//     byte into a shadow register, which CNT_HI later returns;
//   - a programmable alarm compare with an atomic two-byte commit;
//   - a sticky FIRED flag and an OVERRUN flag, both write-1-to-clear;
//   - a registered level interrupt (irq = FIRED & IRQ_EN, one cycle late).
//
// Optional feature (macro TIMER_ALARM_RELOAD_EN): a period register
// (addresses 6/7) and CTRL.RELOAD. On each match with RELOAD set, the alarm
// advances by the period. Without the macro, addresses 6/7 and CTRL bit3
// read 0 and ignore writes.
//
// Parameters:
//   COUNTER_WIDTH  width of the counter input, 9..16. Bits above it read 0.
//
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset
//   counter  tick count. It advances by +1 (with wrap) at most once per cycle.
//   bus      CPU I/O bus (timer_alarm_if.slave): cs/rd/wr/addr/din in,
//            dout/irq out
//
// Register map:
//   0 CNT_LO  R    counter[7:0]; snapshots counter[15:8] into the shadow
//   1 CNT_HI  R    shadow high byte
//   2 ALM_LO  R/W  write: stage; read: committed alarm[7:0]
//   3 ALM_HI  R/W  write: commit {din, stage}; read: alarm[15:8]
//   4 CTRL    R/W  bit0 EN, bit1 IRQ_EN, bit2 ONESHOT, bit3 RELOAD
//   5 STAT    R/W1C bit0 FIRED, bit1 OVERRUN
//   6 PER_LO  R/W  (reload build) write: stage; read: committed period[7:0]
//   7 PER_HI  R/W  (reload build) write: commit; read: period[15:8]
// -----------------------------------------------------------------------------
module timer_alarm #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [COUNTER_WIDTH-1:0] counter,
    timer_alarm_if.slave             bus
);

    localparam int CW = COUNTER_WIDTH;

    typedef enum logic [2:0] {
        A_CNT_LO = 3'd0,
        A_CNT_HI = 3'd1,
        A_ALM_LO = 3'd2,
        A_ALM_HI = 3'd3,
        A_CTRL   = 3'd4,
        A_STAT   = 3'd5,
        A_PER_LO = 3'd6,
        A_PER_HI = 3'd7
    } reg_addr_e;

    typedef struct packed {
        logic reload;
        logic oneshot;
        logic irq_en;
        logic en;
    } ctrl_t;

    // State
    logic [CW-1:0] counter_prev_q;
    logic [CW-1:0] alarm_q,          alarm_d;
    logic [7:0]    alarm_stage_lo_q, alarm_stage_lo_d;
    logic [7:0]    shadow_hi_q,      shadow_hi_d;
    ctrl_t         ctrl_q,           ctrl_d;
    logic          fired_q,          fired_d;
    logic          overrun_q,        overrun_d;
    logic [7:0]    dout_q,           dout_d;
    logic          irq_q,            irq_d;
`ifdef TIMER_ALARM_RELOAD_EN
    logic [CW-1:0] period_q,         period_d;
    logic [7:0]    period_stage_lo_q, period_stage_lo_d;
    logic [15:0]   period_ext;
`endif

    // Decoded access. If rd and wr are both asserted, the write wins and the
    // read is dropped.
    logic      acc_wr;
    logic      acc_rd;
    reg_addr_e acc_addr;

    logic [15:0] counter_ext;
    logic [15:0] alarm_ext;
    logic        tick;
    logic        match;
    logic        alarm_commit;
    logic        clr_fired;

    assign acc_wr   = bus.cs & bus.wr;
    assign acc_rd   = bus.cs & bus.rd & ~bus.wr;
    assign acc_addr = reg_addr_e'(bus.addr);

    // Zero-extend to the 16-bit register view so that unused high bits read 0.
    assign counter_ext = 16'(counter);
    assign alarm_ext   = 16'(alarm_q);
`ifdef TIMER_ALARM_RELOAD_EN
    assign period_ext  = 16'(period_q);
`endif

    // A fire needs a real counter movement. A stalled counter that equals
    // the alarm, or an alarm just committed equal to the current count,
    // stays quiet until the counter comes round again.
    assign tick  = (counter != counter_prev_q);
    assign match = tick & ctrl_q.en & (counter == alarm_q);

    assign alarm_commit = acc_wr & (acc_addr == A_ALM_HI);
    assign clr_fired    = acc_wr & (acc_addr == A_STAT) & bus.din[0];

    // NOTE: every signal assigned in this block gets a default first.
    // Otherwise a path that misses an assignment infers a latch.
    always_comb begin
        alarm_d          = alarm_q;
        alarm_stage_lo_d = alarm_stage_lo_q;
        shadow_hi_d      = shadow_hi_q;
        ctrl_d           = ctrl_q;
        fired_d          = fired_q;
        overrun_d        = overrun_q;
        dout_d           = dout_q;
`ifdef TIMER_ALARM_RELOAD_EN
        period_d          = period_q;
        period_stage_lo_d = period_stage_lo_q;
`endif

        // CPU writes
        if (acc_wr) begin
            unique case (acc_addr)
                A_ALM_LO: alarm_stage_lo_d = bus.din;
                A_ALM_HI: alarm_d          = CW'({bus.din, alarm_stage_lo_q});
                A_CTRL: begin
                    ctrl_d = ctrl_t'(bus.din[3:0]);
`ifndef TIMER_ALARM_RELOAD_EN
                    ctrl_d.reload = 1'b0;
`endif
                end
                A_STAT: begin
                    if (bus.din[0]) fired_d   = 1'b0;
                    if (bus.din[1]) overrun_d = 1'b0;
                end
`ifdef TIMER_ALARM_RELOAD_EN
                A_PER_LO: period_stage_lo_d = bus.din;
                A_PER_HI: period_d          = CW'({bus.din, period_stage_lo_q});
`endif
                default: ;
            endcase
        end

        // CPU reads. The data appears on dout one cycle later and holds.
        if (acc_rd) begin
            unique case (acc_addr)
                A_CNT_LO: begin
                    dout_d      = counter_ext[7:0];
                    shadow_hi_d = counter_ext[15:8];
                end
                A_CNT_HI: dout_d = shadow_hi_q;
                A_ALM_LO: dout_d = alarm_ext[7:0];
                A_ALM_HI: dout_d = alarm_ext[15:8];
                A_CTRL:   dout_d = {4'b0000, ctrl_q};
                A_STAT:   dout_d = {6'b000000, overrun_q, fired_q};
`ifdef TIMER_ALARM_RELOAD_EN
                A_PER_LO: dout_d = period_ext[7:0];
                A_PER_HI: dout_d = period_ext[15:8];
`endif
                default:  dout_d = 8'h00;
            endcase
        end

        // A match comes after the CPU write, so it overrides a same-cycle
        // STAT clear and a same-cycle CTRL.EN write. OVERRUN means "fired
        // while unacknowledged". If the CPU clears FIRED in this same cycle,
        // the old FIRED does not count.
        if (match) begin
            fired_d = 1'b1;
            if (fired_q && !clr_fired) overrun_d = 1'b1;
            if (ctrl_q.oneshot)        ctrl_d.en = 1'b0;
`ifdef TIMER_ALARM_RELOAD_EN
            // An explicit CPU commit in the same cycle takes priority over
            // the automatic advance.
            if (ctrl_q.reload && !alarm_commit) alarm_d = alarm_q + period_q;
`endif
        end

        // Built from registered state, so irq follows FIRED/IRQ_EN by a cycle.
        irq_d = fired_q & ctrl_q.irq_en;
    end

    // NOTE: sequential state uses non-blocking assignments only. This lets
    // every flop sample the pre-edge values, whatever order the statements
    // are in.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Load the current count so that no tick shows up on the first
            // cycle after reset.
            counter_prev_q   <= counter;
            alarm_q          <= '0;
            alarm_stage_lo_q <= '0;
            shadow_hi_q      <= '0;
            ctrl_q           <= '0;
            fired_q          <= 1'b0;
            overrun_q        <= 1'b0;
            dout_q           <= '0;
            irq_q            <= 1'b0;
`ifdef TIMER_ALARM_RELOAD_EN
            period_q          <= '0;
            period_stage_lo_q <= '0;
`endif
        end else begin
            counter_prev_q   <= counter;
            alarm_q          <= alarm_d;
            alarm_stage_lo_q <= alarm_stage_lo_d;
            shadow_hi_q      <= shadow_hi_d;
            ctrl_q           <= ctrl_d;
            fired_q          <= fired_d;
            overrun_q        <= overrun_d;
            dout_q           <= dout_d;
            irq_q            <= irq_d;
`ifdef TIMER_ALARM_RELOAD_EN
            period_q          <= period_d;
            period_stage_lo_q <= period_stage_lo_d;
`endif
        end
    end

    assign bus.dout = dout_q;
    assign bus.irq  = irq_q;

endmodule : timer_alarm

// File: tb/tb_timer_alarm.sv
// -----------------------------------------------------------------------------
// tb_timer_alarm
//
// Directed bench for timer_alarm (COUNTER_WIDTH = 16). Inputs change on the
// falling edge and outputs are sampled on the falling edge, so each bus task
// spans exactly one rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_timer_alarm;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] counter;
    logic [7:0]  rdata;

    int vectors     = 0;
    int miscompares = 0;

    timer_alarm_if bus_if ();

    timer_alarm #(
        .COUNTER_WIDTH (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .counter (counter),
        .bus     (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        bus_if.cs   = 1'b1;
        bus_if.wr   = 1'b1;
        bus_if.addr = a;
        bus_if.din  = d;
        @(negedge clk);
        bus_if.cs   = 1'b0;
        bus_if.wr   = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
        bus_if.cs   = 1'b1;
        bus_if.rd   = 1'b1;
        bus_if.addr = a;
        @(negedge clk);
        bus_if.cs   = 1'b0;
        bus_if.rd   = 1'b0;
        d = bus_if.dout;
    endtask

    task automatic set_cnt(input logic [15:0] v);
        counter = v;
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        counter     = 16'h0000;
        bus_if.cs   = 1'b0;
        bus_if.rd   = 1'b0;
        bus_if.wr   = 1'b0;
        bus_if.addr = 3'd0;
        bus_if.din  = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_dout", bus_if.dout, 16'h00);
        check("rst_irq",  bus_if.irq,  16'h0);
        reset = 1'b0;
        rd_reg(3'd5, rdata); check("rst_stat",   rdata, 16'h00);
        rd_reg(3'd4, rdata); check("rst_ctrl",   rdata, 16'h00);
        rd_reg(3'd2, rdata); check("rst_alm_lo", rdata, 16'h00);

        // Torn read: the high byte comes from the snapshot, not the live count
        set_cnt(16'h12FF);
        rd_reg(3'd0, rdata); check("torn_lo", rdata, 16'hFF);
        set_cnt(16'h1300);
        rd_reg(3'd1, rdata); check("torn_hi", rdata, 16'h12);
        repeat (3) @(negedge clk);
        check("dout_hold", bus_if.dout, 16'h12);

`ifndef TIMER_ALARM_RELOAD_EN
        // Reload logic absent: CTRL bit3 and addresses 6/7 read 0
        wr_reg(3'd4, 8'h08);
        rd_reg(3'd4, rdata); check("ctrl_bit3_ignored", rdata, 16'h00);
        wr_reg(3'd6, 8'hAA);
        wr_reg(3'd7, 8'h55);
        rd_reg(3'd6, rdata); check("per_lo_absent", rdata, 16'h00);
        rd_reg(3'd7, rdata); check("per_hi_absent", rdata, 16'h00);
`endif
        wr_reg(3'd4, 8'h00);

        // Alarm fire at 0x0005, irq one cycle after FIRED
        set_cnt(16'h0003);
        wr_reg(3'd2, 8'h05);
        wr_reg(3'd3, 8'h00);
        wr_reg(3'd4, 8'h03);
        rd_reg(3'd2, rdata); check("alm_lo_rb", rdata, 16'h05);
        set_cnt(16'h0004);
        check("irq_before_match", bus_if.irq, 16'h0);
        set_cnt(16'h0005);
        check("irq_lag", bus_if.irq, 16'h0);
        @(negedge clk);
        check("irq_fire", bus_if.irq, 16'h1);
        repeat (10) @(negedge clk);
        rd_reg(3'd5, rdata); check("stall_no_overrun", rdata, 16'h01);

        // Clear race: a STAT clear in the same cycle as a second match
        wr_reg(3'd2, 8'h06);
        wr_reg(3'd3, 8'h00);
        counter     = 16'h0006;
        bus_if.cs   = 1'b1;
        bus_if.wr   = 1'b1;
        bus_if.addr = 3'd5;
        bus_if.din  = 8'h01;
        @(negedge clk);
        bus_if.cs   = 1'b0;
        bus_if.wr   = 1'b0;
        rd_reg(3'd5, rdata); check("clear_race", rdata, 16'h01);
        wr_reg(3'd2, 8'h07);
        wr_reg(3'd3, 8'h00);
        set_cnt(16'h0007);
        rd_reg(3'd5, rdata); check("overrun_set", rdata, 16'h03);

        // Clearing IRQ_EN drops irq the next cycle; FIRED is kept
        wr_reg(3'd4, 8'h01);
        check("irq_en_clr_lag", bus_if.irq, 16'h1);
        @(negedge clk);
        check("irq_en_clr", bus_if.irq, 16'h0);
        wr_reg(3'd5, 8'h00);
        rd_reg(3'd5, rdata); check("stat_w0_noop", rdata, 16'h03);
        wr_reg(3'd5, 8'h03);
        rd_reg(3'd5, rdata); check("stat_w1c", rdata, 16'h00);

        // Oneshot with alarm = 0: fires on the wrap, then stays disabled
        wr_reg(3'd4, 8'h00);
        set_cnt(16'hFFFE);
        wr_reg(3'd2, 8'h00);
        wr_reg(3'd3, 8'h00);
        wr_reg(3'd4, 8'h07);
        set_cnt(16'hFFFF);
        rd_reg(3'd5, rdata); check("wrap_pre", rdata, 16'h00);
        set_cnt(16'h0000);
        rd_reg(3'd4, rdata); check("oneshot_en_clr", rdata, 16'h06);
        rd_reg(3'd5, rdata); check("wrap_fire", rdata, 16'h01);
        check("wrap_irq", bus_if.irq, 16'h1);
        set_cnt(16'hFFFF);
        set_cnt(16'h0000);
        rd_reg(3'd5, rdata); check("oneshot_no_refire", rdata, 16'h01);
        wr_reg(3'd5, 8'h03);
        wr_reg(3'd4, 8'h00);

        // Arm with the alarm equal to the stalled count: no fire until it returns
        set_cnt(16'h0040);
        wr_reg(3'd2, 8'h40);
        wr_reg(3'd3, 8'h00);
        wr_reg(3'd4, 8'h03);
        repeat (5) @(negedge clk);
        rd_reg(3'd5, rdata); check("arm_eq_quiet", rdata, 16'h00);
        check("arm_eq_irq", bus_if.irq, 16'h0);
        set_cnt(16'h003F);
        rd_reg(3'd5, rdata); check("arm_eq_away", rdata, 16'h00);
        set_cnt(16'h0040);
        rd_reg(3'd5, rdata); check("arm_eq_return", rdata, 16'h01);
        check("arm_eq_irq_fire", bus_if.irq, 16'h1);
        wr_reg(3'd5, 8'h03);
        wr_reg(3'd4, 8'h00);

        // CTRL write racing a oneshot fire: the auto-clear of EN wins
        wr_reg(3'd2, 8'h41);
        wr_reg(3'd3, 8'h00);
        wr_reg(3'd4, 8'h05);
        counter     = 16'h0041;
        bus_if.cs   = 1'b1;
        bus_if.wr   = 1'b1;
        bus_if.addr = 3'd4;
        bus_if.din  = 8'h05;
        @(negedge clk);
        bus_if.cs   = 1'b0;
        bus_if.wr   = 1'b0;
        rd_reg(3'd4, rdata); check("ctrl_race_en", rdata, 16'h04);
        rd_reg(3'd5, rdata); check("ctrl_race_fire", rdata, 16'h01);
        wr_reg(3'd5, 8'h03);

        // ALM_HI commit in the match cycle: the old alarm fires, the new one sticks
        wr_reg(3'd2, 8'h42);
        wr_reg(3'd3, 8'h00);
        wr_reg(3'd4, 8'h01);
        wr_reg(3'd2, 8'h50);
        counter     = 16'h0042;
        bus_if.cs   = 1'b1;
        bus_if.wr   = 1'b1;
        bus_if.addr = 3'd3;
        bus_if.din  = 8'h00;
        @(negedge clk);
        bus_if.cs   = 1'b0;
        bus_if.wr   = 1'b0;
        rd_reg(3'd5, rdata); check("commit_race_fire", rdata, 16'h01);
        rd_reg(3'd2, rdata); check("commit_race_alm", rdata, 16'h50);
        wr_reg(3'd5, 8'h03);
        wr_reg(3'd4, 8'h00);

`ifdef TIMER_ALARM_RELOAD_EN
        // Reload: alarm advances by the period on every fire
        set_cnt(16'h000F);
        wr_reg(3'd2, 8'h10);
        wr_reg(3'd3, 8'h00);
        wr_reg(3'd6, 8'h10);
        wr_reg(3'd7, 8'h00);
        wr_reg(3'd4, 8'h09);
        set_cnt(16'h0010);
        rd_reg(3'd2, rdata); check("reload_1", rdata, 16'h20);
        rd_reg(3'd5, rdata); check("reload_fire1", rdata, 16'h01);
        set_cnt(16'h001F);
        set_cnt(16'h0020);
        rd_reg(3'd2, rdata); check("reload_2", rdata, 16'h30);
        set_cnt(16'h002F);
        set_cnt(16'h0030);
        rd_reg(3'd2, rdata); check("reload_3", rdata, 16'h40);
        rd_reg(3'd3, rdata); check("reload_3_hi", rdata, 16'h00);
        rd_reg(3'd5, rdata); check("reload_overrun", rdata, 16'h03);
        rd_reg(3'd6, rdata); check("period_rb", rdata, 16'h10);
`endif

        // Reset in the middle of a read discards the pending data
        set_cnt(16'h3377);
        rd_reg(3'd0, rdata); check("pre_reset_read", rdata, 16'h77);
        bus_if.cs   = 1'b1;
        bus_if.rd   = 1'b1;
        bus_if.addr = 3'd0;
        reset       = 1'b1;
        @(negedge clk);
        bus_if.cs   = 1'b0;
        bus_if.rd   = 1'b0;
        check("reset_mid_read", bus_if.dout, 16'h00);
        reset = 1'b0;
        rd_reg(3'd1, rdata); check("reset_shadow", rdata, 16'h00);
        rd_reg(3'd5, rdata); check("reset_stat",   rdata, 16'h00);
        check("reset_irq", bus_if.irq, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_timer_alarm
